// File: rtl/ref_clk_divider.sv
// ---------------------------------------------------------------------------
// ref_clk_divider
//
// Programmable reference-clock divider. Takes the one-hot ratio select coming
// from the reference-clock select decoder, synchronises it into the fast clock
// domain, validates it, and switches the division ratio only at a period
// boundary. This keeps ref_clk_out free of runt pulses across ratio changes.
//
// Ratio select encoding (tgate_control / ratio_active):
//   bit 4 -> /32, bit 3 -> /64, bit 2 -> /128, bit 1 -> /256, bit 0 -> /512
//
// Parameters:
//   CNT_W    period counter width; must hold 0..511 for the /512 ratio
//   RST_SEL  one-hot ratio loaded on reset (default /256)
//
// Ports:
//   clk             in   fast source clock, rising edge
//   rstn            in   synchronous active-low reset
//   tgate_control   in   [4:0] one-hot ratio select, asynchronous to clk
//   ref_clk_out     out  divided clock, 50 % duty, registered
//   period_strobe   out  one-cycle pulse in the first cycle of each period
//   ratio_active    out  [4:0] one-hot ratio currently in use
//   switch_pending  out  a valid, different ratio waits for the next boundary
//   sel_err         out  synchronised select is not one-hot
// ---------------------------------------------------------------------------
module ref_clk_divider #(
    parameter int unsigned CNT_W   = 9,
    parameter logic [4:0]  RST_SEL = 5'b00010
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] tgate_control,
    output logic       ref_clk_out,
    output logic       period_strobe,
    output logic [4:0] ratio_active,
    output logic       switch_pending,
    output logic       sel_err
);

    // Two-flop synchroniser for the asynchronous select.
    logic [4:0] sel_s1;
    logic [4:0] sel_s2;

    // Period counter and the decoded compare points for the active ratio.
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_last;       // N - 1
    logic [CNT_W-1:0] cnt_half_last;  // N/2 - 1

    logic sel_valid;
    logic switch_req;
    logic wrap;
    logic half_hit;

    // -----------------------------------------------------------------------
    // Select synchroniser
    // -----------------------------------------------------------------------
    // Both stages reset to the reset ratio so that a select held at its
    // default value never looks like a pending switch coming out of reset.
    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sel_s1 <= RST_SEL;
            sel_s2 <= RST_SEL;
        end else begin
            sel_s1 <= tgate_control;
            sel_s2 <= sel_s1;
        end
    end

    // One-hot test: non-zero, and clearing the lowest set bit leaves nothing.
    assign sel_valid  = (sel_s2 != 5'd0) && ((sel_s2 & (sel_s2 - 5'd1)) == 5'd0);
    assign switch_req = sel_valid && (sel_s2 != ratio_active);

    // -----------------------------------------------------------------------
    // Ratio decode
    // -----------------------------------------------------------------------
    // ratio_active is only ever loaded from a validated one-hot value, so the
    // default arm is unreachable in operation; it falls back to /256.
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_last      = CNT_W'(255);
        cnt_half_last = CNT_W'(127);
        case (ratio_active)
            5'b10000: begin
                cnt_last      = CNT_W'(31);
                cnt_half_last = CNT_W'(15);
            end
            5'b01000: begin
                cnt_last      = CNT_W'(63);
                cnt_half_last = CNT_W'(31);
            end
            5'b00100: begin
                cnt_last      = CNT_W'(127);
                cnt_half_last = CNT_W'(63);
            end
            5'b00010: begin
                cnt_last      = CNT_W'(255);
                cnt_half_last = CNT_W'(127);
            end
            5'b00001: begin
                cnt_last      = CNT_W'(511);
                cnt_half_last = CNT_W'(255);
            end
            default: begin
                cnt_last      = CNT_W'(255);
                cnt_half_last = CNT_W'(127);
            end
        endcase
    end

    assign wrap     = (cnt == cnt_last);
    assign half_hit = (cnt == cnt_half_last);

    // -----------------------------------------------------------------------
    // Period counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Ratio register
    // -----------------------------------------------------------------------
    // The new ratio is loaded on the same edge the counter wraps, so the next
    // period starts cleanly at count 0 with the new compare points. A select
    // that has already reverted by the wrap produces no change, and an
    // invalid select never raises switch_req, so the ratio simply holds.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ratio_active <= RST_SEL;
        end else if (wrap && switch_req) begin
            ratio_active <= sel_s2;
        end
    end

    // -----------------------------------------------------------------------
    // Output clock and status flags
    // -----------------------------------------------------------------------
    // ref_clk_out is low for counts 0..HALF-1 and high for HALF..N-1. It is
    // cleared on the wrap edge, so a ratio change always starts from a low
    // phase and the previous high phase is never cut short.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ref_clk_out <= 1'b0;
        end else if (wrap) begin
            ref_clk_out <= 1'b0;
        end else if (half_hit) begin
            ref_clk_out <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            period_strobe  <= 1'b0;
            switch_pending <= 1'b0;
            sel_err        <= 1'b0;
        end else begin
            period_strobe  <= wrap;
            switch_pending <= switch_req;
            sel_err        <= !sel_valid;
        end
    end

endmodule

// File: tb/tb_ref_clk_divider.sv
module tb_ref_clk_divider;

    logic       clk;
    logic       rstn;
    logic [4:0] tgate_control;
    logic       ref_clk_out;
    logic       period_strobe;
    logic [4:0] ratio_active;
    logic       switch_pending;
    logic       sel_err;

    ref_clk_divider dut (
        .clk            (clk),
        .rstn           (rstn),
        .tgate_control  (tgate_control),
        .ref_clk_out    (ref_clk_out),
        .period_strobe  (period_strobe),
        .ratio_active   (ratio_active),
        .switch_pending (switch_pending),
        .sel_err        (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cycle_no);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: counter-phase view of the divider. The output level is
    // derived from the phase (high in the second half), not tracked as a flop.
    // -----------------------------------------------------------------------
    int         m_cnt;
    logic [4:0] m_ratio, m_s1, m_s2;
    logic       m_strobe, m_pend, m_err;

    // Expected output word: {ref_clk_out, period_strobe, ratio_active, switch_pending, sel_err}
    logic [8:0] sb_q[$];

    function automatic int ratio_n(input logic [4:0] r);
        case (r)
            5'b10000: return 32;
            5'b01000: return 64;
            5'b00100: return 128;
            5'b00001: return 512;
            default:  return 256;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic [4:0] s);
        int   n;
        logic valid;
        logic out;
        if (!r) begin
            m_cnt = 0; m_ratio = 5'b00010; m_s1 = 5'b00010; m_s2 = 5'b00010;
            m_strobe = 1'b0; m_pend = 1'b0; m_err = 1'b0;
        end else begin
            n        = ratio_n(m_ratio);
            valid    = ($countones(m_s2) == 1);
            m_strobe = (m_cnt == n - 1);
            m_pend   = valid && (m_s2 != m_ratio);
            m_err    = !valid;
            if (m_strobe && m_pend) m_ratio = m_s2;
            m_cnt    = m_strobe ? 0 : m_cnt + 1;
            m_s2     = m_s1;
            m_s1     = s;
        end
        out = (m_cnt >= ratio_n(m_ratio) / 2);
        sb_q.push_back({out, m_strobe, m_ratio, m_pend, m_err});
    endtask

    // One clock: drive inputs, push the expectation, sample #1 after the edge.
    task automatic step(input logic r, input logic [4:0] s);
        logic [8:0] e;
        rstn          = r;
        tgate_control = s;
        model_edge(r, s);
        @(posedge clk);
        #1;
        cycle_no++;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check("cycle", {ref_clk_out, period_strobe, ratio_active, switch_pending, sel_err}, e);
        end
    endtask

    // -----------------------------------------------------------------------
    // Vector table: phases of constant input, with the end-of-phase ratio and
    // error flag derived by hand.
    // -----------------------------------------------------------------------
    typedef struct {
        logic       rst;
        logic [4:0] sel;
        int         cycles;
        logic [4:0] exp_ratio;
        logic       exp_err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bit found;
        rstn = 1'b0;
        tgate_control = 5'b00010;

        vecs[0] = '{1'b0, 5'b00010,   3, 5'b00010, 1'b0};  // reset
        vecs[1] = '{1'b1, 5'b00010, 600, 5'b00010, 1'b0};  // default /256
        vecs[2] = '{1'b1, 5'b10000, 300, 5'b10000, 1'b0};  // -> /32
        vecs[3] = '{1'b1, 5'b00000,  50, 5'b10000, 1'b1};  // zero select
        vecs[4] = '{1'b1, 5'b00011,  50, 5'b10000, 1'b1};  // two bits set
        vecs[5] = '{1'b1, 5'b01000, 100, 5'b01000, 1'b0};  // -> /64
        vecs[6] = '{1'b1, 5'b00100, 200, 5'b00100, 1'b0};  // -> /128
        vecs[7] = '{1'b1, 5'b00001, 200, 5'b00001, 1'b0};  // -> /512
        vecs[8] = '{1'b1, 5'b00010, 600, 5'b00010, 1'b0};  // -> /256

        for (int v = 0; v < 9; v++) begin
            for (int c = 0; c < vecs[v].cycles; c++) step(vecs[v].rst, vecs[v].sel);
            check($sformatf("vec%0d_ratio", v), ratio_active, vecs[v].exp_ratio);
            check($sformatf("vec%0d_err", v), sel_err, vecs[v].exp_err);
        end

        // A: reset default timing, then 256 -> 32 requested after edge 40.
        step(1'b0, 5'b00010);
        check("a_reset_out", ref_clk_out, 0);
        check("a_reset_cnt", dut.cnt, 0);
        for (int k = 1; k <= 320; k++) begin
            step(1'b1, (k >= 41) ? 5'b10000 : 5'b00010);
            if (k == 1)   check("a_first_cnt", dut.cnt, 1);
            if (k == 1)   check("a_first_out", ref_clk_out, 0);
            if (k == 127) check("a_out_pre_rise", ref_clk_out, 0);
            if (k == 128) check("a_out_rise128", ref_clk_out, 1);
            if (k == 42)  check("a_pend_pre", switch_pending, 0);
            if (k == 43)  check("a_pend_set", switch_pending, 1);
            if (k == 150) check("a_pend_hold", switch_pending, 1);
            if (k == 255) check("a_ratio_old", ratio_active, 5'b00010);
            if (k == 255) check("a_out_high_end", ref_clk_out, 1);
            if (k == 256) check("a_ratio_new", ratio_active, 5'b10000);
            if (k == 256) check("a_out_fall256", ref_clk_out, 0);
            if (k == 256) check("a_strobe256", period_strobe, 1);
            if (k == 257) check("a_pend_fall", switch_pending, 0);
            if (k == 271) check("a_out_pre_rise32", ref_clk_out, 0);
            if (k == 272) check("a_out_rise272", ref_clk_out, 1);
            if (k == 288) check("a_out_fall288", ref_clk_out, 0);
            if (k == 288) check("a_strobe288", period_strobe, 1);
            if (k == 304) check("a_out_rise304", ref_clk_out, 1);
        end

        // B: sel_s2 becomes /128 exactly in the wrap cycle (cnt = 255).
        step(1'b0, 5'b00010);
        for (int k = 1; k <= 400; k++) begin
            step(1'b1, (k >= 254) ? 5'b00100 : 5'b00010);
            if (k == 254) check("b_s2_pre", dut.sel_s2, 5'b00010);
            if (k == 255) check("b_s2_at_wrap", dut.sel_s2, 5'b00100);
            if (k == 255) check("b_cnt_at_wrap", dut.cnt, 255);
            if (k == 256) check("b_ratio_new", ratio_active, 5'b00100);
            if (k == 256) check("b_cnt_zero", dut.cnt, 0);
            if (k == 319) check("b_out_pre_rise", ref_clk_out, 0);
            if (k == 320) check("b_out_rise320", ref_clk_out, 1);
            if (k == 384) check("b_strobe384", period_strobe, 1);
            if (k == 384) check("b_out_fall384", ref_clk_out, 0);
        end

        // C: /512 select pulsed for 10 cycles, then reverted.
        step(1'b0, 5'b00010);
        for (int k = 1; k <= 520; k++) begin
            step(1'b1, (k >= 51 && k <= 60) ? 5'b00001 : 5'b00010);
            if (k == 52)  check("c_pend_pre", switch_pending, 0);
            if (k == 53)  check("c_pend_set", switch_pending, 1);
            if (k == 62)  check("c_pend_hold", switch_pending, 1);
            if (k == 63)  check("c_pend_clear", switch_pending, 0);
            if (k == 256) check("c_ratio_kept", ratio_active, 5'b00010);
            if (k == 256) check("c_out_fall256", ref_clk_out, 0);
            if (k == 383) check("c_out_pre_rise", ref_clk_out, 0);
            if (k == 384) check("c_out_rise384", ref_clk_out, 1);
            if (k == 512) check("c_strobe512", period_strobe, 1);
        end

        // D: reset while ref_clk_out is high at /64.
        step(1'b0, 5'b00010);
        found = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            step(1'b1, 5'b01000);
            if (ref_clk_out && ratio_active == 5'b01000) begin
                found = 1'b1;
                break;
            end
        end
        check("d_reach_div64_high", found, 1);
        step(1'b0, 5'b01000);
        check("d_rst_out", ref_clk_out, 0);
        check("d_rst_cnt", dut.cnt, 0);
        check("d_rst_ratio", ratio_active, 5'b00010);
        check("d_rst_strobe", period_strobe, 0);
        check("d_rst_pend", switch_pending, 0);
        check("d_rst_err", sel_err, 0);
        step(1'b1, 5'b00010);
        check("d_release_cnt", dut.cnt, 1);
        check("d_release_out", ref_clk_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
